// File: rtl/dual_stream_align_pkg.sv
// Shared types and helpers for the dual-stream aligner.
package dual_stream_align_pkg;

  typedef enum logic [1:0] {
    StPass   = 2'd0,
    StDrain0 = 2'd1,
    StDrain1 = 2'd2
  } align_state_e;

  localparam int unsigned MaxCntW = 32;

  // Increment that sticks at the all-ones value of a cnt_w-bit counter.
  function automatic logic [MaxCntW-1:0] sat_inc(input logic [MaxCntW-1:0] val,
                                                 input int unsigned       cnt_w);
    logic [MaxCntW-1:0] max_val;
    max_val = (cnt_w >= MaxCntW) ? '1 : ((MaxCntW'(1) << cnt_w) - MaxCntW'(1));
    sat_inc = (val >= max_val) ? max_val : val + MaxCntW'(1);
  endfunction

endpackage

// File: rtl/axis_pair_reg.sv
// Single-stage output register for a lock-stepped pair of streams.
module axis_pair_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in0_data,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in_last,
  output logic             load_en,
  output logic [WIDTH-1:0] out0_data,
  output logic [WIDTH-1:0] out1_data,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             valid_q;
  logic             last_q;
  logic [WIDTH-1:0] d0_q;
  logic [WIDTH-1:0] d1_q;

  assign load_en = ~valid_q | out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      d0_q    <= '0;
      d1_q    <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load_en) begin
      valid_q <= in_valid;
      if (in_valid) begin
        d0_q   <= in0_data;
        d1_q   <= in1_data;
        last_q <= in_last;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out0_data = d0_q;
  assign out1_data = d1_q;

endmodule

// File: rtl/dual_stream_align.sv
// Joins two sample streams into one lock-stepped pair stream; drains the longer packet
// when only one input ends a packet, and counts packets, mismatches and dropped beats.
module dual_stream_align
  import dual_stream_align_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] i0_tdata,
  input  logic             i0_tlast,
  input  logic             i0_tvalid,
  output logic             i0_tready,
  input  logic [WIDTH-1:0] i1_tdata,
  input  logic             i1_tlast,
  input  logic             i1_tvalid,
  output logic             i1_tready,
  output logic [WIDTH-1:0] o0_tdata,
  output logic [WIDTH-1:0] o1_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  align_state_e     state_q, state_d;
  logic             load_en;
  logic             joint;
  logic [CNT_W-1:0] pkt_q, pkt_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  always_comb begin
    state_d   = state_q;
    pkt_d     = pkt_q;
    err_d     = err_q;
    drop_d    = drop_q;
    i0_tready = 1'b0;
    i1_tready = 1'b0;
    joint     = 1'b0;
    if (clear) begin
      state_d = StPass;
      pkt_d   = '0;
      err_d   = '0;
      drop_d  = '0;
    end else if (reset_n) begin
      unique case (state_q)
        StPass: begin
          // Each ready looks only at the other stream's valid, so a beat is taken only
          // when both sides present one.
          i0_tready = load_en & i1_tvalid;
          i1_tready = load_en & i0_tvalid;
          joint     = load_en & i0_tvalid & i1_tvalid;
          if (joint && (i0_tlast || i1_tlast)) begin
            pkt_d = pkt_q + CNT_W'(1);
            if (i0_tlast != i1_tlast) begin
              err_d   = CNT_W'(sat_inc(MaxCntW'(err_q), CNT_W));
              state_d = i0_tlast ? StDrain1 : StDrain0;
            end
          end
        end
        StDrain1: begin
          i1_tready = 1'b1;
          if (i1_tvalid) begin
            drop_d = CNT_W'(sat_inc(MaxCntW'(drop_q), CNT_W));
            if (i1_tlast) state_d = StPass;
          end
        end
        StDrain0: begin
          i0_tready = 1'b1;
          if (i0_tvalid) begin
            drop_d = CNT_W'(sat_inc(MaxCntW'(drop_q), CNT_W));
            if (i0_tlast) state_d = StPass;
          end
        end
        default: state_d = StPass;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StPass;
      pkt_q   <= '0;
      err_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  axis_pair_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .in_valid (joint),
    .in0_data (i0_tdata),
    .in1_data (i1_tdata),
    .in_last  (i0_tlast | i1_tlast),
    .load_en  (load_en),
    .out0_data(o0_tdata),
    .out1_data(o1_tdata),
    .out_last (o_tlast),
    .out_valid(o_tvalid),
    .out_ready(o_tready)
  );

  assign pkt_cnt  = pkt_q;
  assign err_cnt  = err_q;
  assign drop_cnt = drop_q;

endmodule
